segasys_ioctl_mbox: RTL and testbench
=====================================

Name: segasys_ioctl_mbox

Overview:
- Parametrised main-CPU I/O control block for System 1/2 cores.
- Replaces the fixed video-mode, sound-control and sound-request latches in the main CPU wrapper with:
  - N decoded output latches;
  - a queued sound-command mailbox with a req/ack handshake toward the sound CPU;
  - ROM bank-select generation.
- Sits between the Z80 bus (IORQ cycles, address low byte) and the video/sound subsystems.
- Supplies readback data to the main CPU data selector.

Parameters:
- NLATCH, 4: number of output latches; legal range 2..8. Latch 0 is the video mode latch, latch 1 is the sound control latch.
- DW, 8: data width of latches and commands.
- QDEPTH, 4: sound-command queue depth; power of two, 2..16.
- PORT_BASE, 8'h14: I/O address of the command port. Latch k sits at PORT_BASE+1+k.

Ports:
- CLK40M  in  1  system clock.
- RESET_N  in  1  synchronous active-low reset.
- CPUAD  in  8  CPU address low byte.
- CPUDO  in  DW  CPU write data.
- CPUIORQ  in  1  CPU I/O request, level.
- CPUWR  in  1  CPU write strobe, level, held for many CLK40M cycles.
- SYSTEM2  in  1  bank mode select.
- SNDACK  in  1  sound-side acknowledge, level.
- LATCH  out  NLATCH*DW  latch k occupies bits [k*DW +: DW].
- BANK  out  2  main ROM bank select.
- SNDRQ  out  1  sound request, level.
- SNDNO  out  DW  current sound command.
- QFULL  out  1  queue full.
- QOVF  out  1  sticky overflow flag.
- DV  out  1  readback valid (address decoded and CPUIORQ high).
- OD  out  DW  readback data.

Behaviour:
- Write strobe:
  - wstb = CPUIORQ & CPUWR, registered once.
  - A write event is the rising edge of wstb: sampled high at edge E0, low at the edge before.
  - Exactly one action per CPU write, regardless of strobe length.
- Latch write: a write event with CPUAD == PORT_BASE+1+k loads latch k with CPUDO at E0. Addresses outside the decoded set are ignored.
- Command write:
  - A write event at PORT_BASE pushes CPUDO into the queue at E0.
  - Queue full and no pop at E0: data dropped, QOVF set, stays set until reset.
  - Queue full and pop at E0: push accepted; count unchanged.
- Handshake FSM, states IDLE, REQ, REL:
  - IDLE: SNDRQ=0. When the queue is non-empty at an edge, load SNDNO from the head, go to REQ.
    - SNDRQ first visible after E0+1 for a push into an empty idle queue.
  - REQ: SNDRQ=1. On SNDACK sampled high, pop the head, go to REL.
    - SNDRQ deasserts at the same edge.
  - REL: SNDRQ=0. Wait for SNDACK sampled low, then go to IDLE.
    - A further queued command raises SNDRQ no earlier than one edge after entry to IDLE.
  - SNDNO holds its last value outside REQ.
- Queue:
  - Read/write pointers wrap modulo QDEPTH.
  - Count width is clog2(QDEPTH)+1.
  - QFULL = (count == QDEPTH).
- Bank select:
  - BANK[1] = SYSTEM2 ? latch0[3] : latch0[6].
  - BANK[0] = latch0[2].
  - BANK is combinational from the latch register.
- Readback, combinational:
  - CPUIORQ high and CPUAD == PORT_BASE+1+k: DV=1, OD = latch k.
  - Otherwise DV=0, OD = all ones.
  - The command port is write-only.
- Reset: RESET_N low at an edge clears, at that edge:
  - all latches, BANK, SNDNO, SNDRQ, QOVF and the queue;
  - FSM to IDLE;
  - wstb history to 0, so a strobe already high when reset releases counts as a new event.
  - Reset asserted in REQ drops SNDRQ at that edge; the pending command is discarded.

Optional Feature:
- Macro: SEGASYS_IOCTL_QSTATUS_EN.
- When defined:
  - A status register reads at PORT_BASE+NLATCH+1 with DV=1.
  - OD = {QFULL, empty, QOVF, zero-pad, count}, count in the low bits.
  - The first clock edge of a read with CPUIORQ high and CPUWR low clears QOVF. Clearing happens once per read, using rising-edge detection of the read strobe.
  - A push that overflows at the same edge leaves QOVF set.
- When undefined:
  - That address is not decoded: DV=0, OD all ones.
  - QOVF clears only on reset.

Test Plan:
- Write 8'h4C to PORT_BASE+1, strobe held 13 cycles, SYSTEM2=0 -> latch0=8'h4C, BANK=2'b11, exactly one load. SYSTEM2=1 -> BANK=2'b11 (bit3 set).
- Push 8'h81 to an empty queue, SNDACK low -> SNDRQ=1 and SNDNO=8'h81 visible after E0+1. SNDACK high -> SNDRQ=0 next edge. SNDACK low -> FSM IDLE.
- Push 5 commands 1..5 with QDEPTH=4, SNDACK tied low -> QFULL=1, QOVF=1. Sequence delivered after acking is 1,2,3,4; 5 is lost.
- Queue full, push coincident with ack pop -> count stays 4, new entry delivered last, QOVF unchanged.
- RESET_N low one cycle while SNDRQ=1 and 3 entries queued -> SNDRQ=0, count=0, latches=0 after that edge. Strobe held high through reset release -> one new event.
- With SEGASYS_IOCTL_QSTATUS_EN, after overflow read PORT_BASE+NLATCH+1 -> OD shows QOVF=1, next read shows QOVF=0. Without the macro -> DV=0, OD=8'hFF.

Source files
------------

// File: rtl/segasys_ioctl_mbox_if.sv
// segasys_ioctl_mbox_if
// Bundles the Z80 I/O bus, the sound-CPU handshake and the latch/bank/readback
// outputs of segasys_ioctl_mbox.
//   master : CPU/system side. It drives CPUAD, CPUDO, CPUIORQ, CPUWR, SYSTEM2
//            and SNDACK, and receives everything else.
//   slave  : the ioctl block.
interface segasys_ioctl_mbox_if #(
    parameter int NLATCH = 4,
    parameter int DW     = 8
);
    logic [7:0]           CPUAD;
    logic [DW-1:0]        CPUDO;
    logic                 CPUIORQ;
    logic                 CPUWR;
    logic                 SYSTEM2;
    logic                 SNDACK;
    logic [NLATCH*DW-1:0] LATCH;
    logic [1:0]           BANK;
    logic                 SNDRQ;
    logic [DW-1:0]        SNDNO;
    logic                 QFULL;
    logic                 QOVF;
    logic                 DV;
    logic [DW-1:0]        OD;

    modport master (
        output CPUAD, CPUDO, CPUIORQ, CPUWR, SYSTEM2, SNDACK,
        input  LATCH, BANK, SNDRQ, SNDNO, QFULL, QOVF, DV, OD
    );

    modport slave (
        input  CPUAD, CPUDO, CPUIORQ, CPUWR, SYSTEM2, SNDACK,
        output LATCH, BANK, SNDRQ, SNDNO, QFULL, QOVF, DV, OD
    );
endinterface

// File: rtl/segasys_ioctl_mbox.sv
// segasys_ioctl_mbox
// Main-CPU I/O control block for the System 1/2 cores. It provides:
//   - NLATCH decoded output latches;
//   - a queued sound-command mailbox with a req/ack handshake;
//   - ROM bank-select generation;
//   - CPU readback.
// Optional build macro SEGASYS_IOCTL_QSTATUS_EN adds a queue status register
// at PORT_BASE+NLATCH+1. Reading it clears the sticky overflow flag.
// Ports:
//   CLK40M   system clock
//   RESET_N  synchronous active-low reset
//   bus      slave modport of segasys_ioctl_mbox_if. It carries:
//              - CPU bus in: CPUAD, CPUDO, CPUIORQ, CPUWR, SYSTEM2;
//              - sound handshake: SNDACK in, SNDRQ/SNDNO out;
//              - LATCH, BANK, QFULL, QOVF;
//              - readback: DV, OD.
module segasys_ioctl_mbox #(
    parameter int         NLATCH    = 4,
    parameter int         DW        = 8,
    parameter int         QDEPTH    = 4,
    parameter logic [7:0] PORT_BASE = 8'h14
) (
    input logic                 CLK40M,
    input logic                 RESET_N,
    segasys_ioctl_mbox_if.slave bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

    logic [NLATCH-1:0][DW-1:0] latch_q;
    logic [DW-1:0]             mem_q [QDEPTH];
    logic [AW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic                      wstb_q;
    state_t                    st_q;
    logic                      sndrq_q;
    logic [DW-1:0]             sndno_q;
    logic                      dv;
    logic [DW-1:0]             od;

    logic wstb, wev, cmd_wr, pop, push, drop, full;

    // One action per CPU write: only the rising edge of the strobe counts.
    assign wstb   = bus.CPUIORQ & bus.CPUWR;
    assign wev    = wstb & ~wstb_q;
    assign cmd_wr = wev && (bus.CPUAD == PORT_BASE);
    assign full   = (cnt_q == CW'(QDEPTH));
    assign pop    = (st_q == S_REQ) && bus.SNDACK;
    // A pop at the same edge frees the head slot, so a full queue still
    // accepts the push. The write lands on the slot being vacated.
    assign push   = cmd_wr && (!full || pop);
    assign drop   = cmd_wr && full && !pop;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

`ifdef SEGASYS_IOCTL_QSTATUS_EN
    localparam logic [7:0] STAT_ADR = 8'(int'(PORT_BASE) + NLATCH + 1);
    logic empty, rstb, rstb_q, rd_clr;
    assign empty  = (cnt_q == '0);
    assign rstb   = bus.CPUIORQ & ~bus.CPUWR & (bus.CPUAD == STAT_ADR);
    assign rd_clr = rstb & ~rstb_q;
    // If an overflow and a clearing read fall on the same edge, the overflow wins.
    assign ovf_d  = drop | (ovf_q & ~rd_clr);
    always_ff @(posedge CLK40M) begin
        if (!RESET_N) rstb_q <= 1'b0;
        else          rstb_q <= rstb;
    end
`else
    assign ovf_d  = drop | ovf_q;
`endif

    always_ff @(posedge CLK40M) begin
        if (!RESET_N) begin
            latch_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            wstb_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            wstb_q <= wstb;
            for (int k = 0; k < NLATCH; k++)
                if (wev && bus.CPUAD == 8'(int'(PORT_BASE) + 1 + k))
                    latch_q[k] <= bus.CPUDO;
        end
    end

    // Queue storage needs no reset: the pointers and count define validity.
    always_ff @(posedge CLK40M) begin
        if (push) mem_q[wptr_q] <= bus.CPUDO;
    end

    // Sound handshake FSM. SNDRQ and SNDNO are registered outputs.
    always_ff @(posedge CLK40M) begin
        if (!RESET_N) begin
            st_q    <= S_IDLE;
            sndrq_q <= 1'b0;
            sndno_q <= '0;
        end else begin
            case (st_q)
                S_IDLE: if (cnt_q != '0) begin
                    sndno_q <= mem_q[rptr_q];
                    sndrq_q <= 1'b1;
                    st_q    <= S_REQ;
                end
                S_REQ: if (bus.SNDACK) begin
                    sndrq_q <= 1'b0;
                    st_q    <= S_REL;
                end
                S_REL: if (!bus.SNDACK) st_q <= S_IDLE;
                default: begin
                    sndrq_q <= 1'b0;
                    st_q    <= S_IDLE;
                end
            endcase
        end
    end

    // Readback. The command port is write-only, so it reads as undecoded.
    always_comb begin
        dv = 1'b0;
        od = '1;
        for (int k = 0; k < NLATCH; k++)
            if (bus.CPUIORQ && bus.CPUAD == 8'(int'(PORT_BASE) + 1 + k)) begin
                dv = 1'b1;
                od = latch_q[k];
            end
`ifdef SEGASYS_IOCTL_QSTATUS_EN
        if (bus.CPUIORQ && bus.CPUAD == STAT_ADR) begin
            dv          = 1'b1;
            od          = '0;
            od[CW-1:0]  = cnt_q;
            od[DW-3]    = ovf_q;
            od[DW-2]    = empty;
            od[DW-1]    = full;
        end
`endif
    end

    assign bus.LATCH = latch_q;
    assign bus.BANK  = {bus.SYSTEM2 ? latch_q[0][3] : latch_q[0][6], latch_q[0][2]};
    assign bus.SNDRQ = sndrq_q;
    assign bus.SNDNO = sndno_q;
    assign bus.QFULL = full;
    assign bus.QOVF  = ovf_q;
    assign bus.DV    = dv;
    assign bus.OD    = od;
endmodule

// File: tb/tb_segasys_ioctl_mbox.sv
// tb_segasys_ioctl_mbox
// Scoreboard bench for segasys_ioctl_mbox with default parameters
// (NLATCH=4, DW=8, QDEPTH=4, PORT_BASE=8'h14). Commands that should be
// accepted are queued on push and compared against SNDNO on each handshake.
module tb_segasys_ioctl_mbox;
    logic gclk = 1'b0;
    logic grst_n = 1'b0;

    segasys_ioctl_mbox_if #(.NLATCH(4), .DW(8)) bus ();

    segasys_ioctl_mbox #(
        .NLATCH(4), .DW(8), .QDEPTH(4), .PORT_BASE(8'h14)
    ) dut (
        .CLK40M (gclk),
        .RESET_N(grst_n),
        .bus    (bus)
    );

    always #5 gclk = ~gclk;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] sb [$];
    int mdl_cnt = 0;
    logic mdl_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; leaves time 1ns past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge gclk);
        #1;
    endtask

    // CPU write with a long strobe. The data changes after the first edge,
    // so a repeated load would show up as the wrong value.
    task automatic cpu_wr(input logic [7:0] adr, input logic [7:0] d, input int hold);
        bus.CPUAD = adr; bus.CPUDO = d; bus.CPUIORQ = 1'b1; bus.CPUWR = 1'b1;
        tick(1);
        bus.CPUDO = ~d;
        if (hold > 1) tick(hold - 1);
        bus.CPUIORQ = 1'b0; bus.CPUWR = 1'b0;
        tick(1);
    endtask

    task automatic push_cmd(input logic [7:0] d);
        if (mdl_cnt < 4) begin
            sb.push_back(d);
            mdl_cnt++;
        end else mdl_ovf = 1'b1;
        cpu_wr(8'h14, d, 2);
    endtask

    task automatic snd_ack();
        logic [7:0] exp;
        int i;
        i = 0;
        while (!bus.SNDRQ && i < 50) begin
            tick(1);
            i++;
        end
        if (!bus.SNDRQ) begin
            chk("sndrq_timeout", 32'(bus.SNDRQ), 32'd1);
            return;
        end
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        exp = sb.pop_front();
        chk("sndno", 32'(bus.SNDNO), 32'(exp));
        bus.SNDACK = 1'b1;
        tick(1);
        chk("sndrq_drop", 32'(bus.SNDRQ), 32'd0);
        bus.SNDACK = 1'b0;
        tick(1);
        mdl_cnt--;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] adr, input logic dv, input logic [7:0] od);
        bus.CPUAD = adr; bus.CPUIORQ = 1'b1; bus.CPUWR = 1'b0;
        #1;
        chk({tag, "_dv"}, 32'(bus.DV), 32'(dv));
        chk({tag, "_od"}, 32'(bus.OD), 32'(od));
        tick(1);
        bus.CPUIORQ = 1'b0;
        tick(1);
    endtask

    initial begin
        bus.CPUAD = '0; bus.CPUDO = '0; bus.CPUIORQ = 1'b0; bus.CPUWR = 1'b0;
        bus.SYSTEM2 = 1'b0; bus.SNDACK = 1'b0;
        tick(3);
        chk("rst_sndrq", 32'(bus.SNDRQ), 32'd0);
        chk("rst_latch", bus.LATCH, 32'd0);
        chk("rst_bank", 32'(bus.BANK), 32'd0);
        chk("rst_qfull", 32'(bus.QFULL), 32'd0);
        chk("rst_qovf", 32'(bus.QOVF), 32'd0);
        chk("rst_dv", 32'(bus.DV), 32'd0);
        chk("rst_od", 32'(bus.OD), 32'hFF);
        grst_n = 1'b1;
        tick(1);

        // Latches and bank select
        cpu_wr(8'h15, 8'h4C, 13);
        chk("latch0_4c", bus.LATCH, 32'h0000_004C);
        chk("bank_s1_4c", 32'(bus.BANK), 32'd3);
        bus.SYSTEM2 = 1'b1; #1;
        chk("bank_s2_4c", 32'(bus.BANK), 32'd3);
        cpu_wr(8'h15, 8'h44, 3);
        chk("bank_s2_44", 32'(bus.BANK), 32'd1);
        bus.SYSTEM2 = 1'b0; #1;
        chk("bank_s1_44", 32'(bus.BANK), 32'd3);
        cpu_wr(8'h16, 8'hA1, 2);
        cpu_wr(8'h17, 8'hB2, 2);
        cpu_wr(8'h18, 8'hC3, 2);
        cpu_wr(8'h1A, 8'h99, 2);
        chk("latch_all", bus.LATCH, 32'hC3B2_A144);
        rd_chk("rd_l0", 8'h15, 1'b1, 8'h44);
        rd_chk("rd_l3", 8'h18, 1'b1, 8'hC3);
        rd_chk("rd_cmd", 8'h14, 1'b0, 8'hFF);
        rd_chk("rd_undec", 8'h1A, 1'b0, 8'hFF);

        // Single command and its handshake latency
        bus.CPUAD = 8'h14; bus.CPUDO = 8'h81; bus.CPUIORQ = 1'b1; bus.CPUWR = 1'b1;
        sb.push_back(8'h81); mdl_cnt = 1;
        tick(1);
        chk("rq_e0", 32'(bus.SNDRQ), 32'd0);
        tick(1);
        chk("rq_e1", 32'(bus.SNDRQ), 32'd1);
        chk("no_e1", 32'(bus.SNDNO), 32'h81);
        bus.CPUIORQ = 1'b0; bus.CPUWR = 1'b0;
        tick(1);
        snd_ack();
        tick(2);
        chk("idle_rq", 32'(bus.SNDRQ), 32'd0);
        chk("idle_no_hold", 32'(bus.SNDNO), 32'h81);

        // Overflow: five pushes into a depth-4 queue
        for (int i = 1; i <= 5; i++) push_cmd(8'(i));
        chk("ovf_qfull", 32'(bus.QFULL), 32'd1);
        chk("ovf_qovf", 32'(bus.QOVF), 32'd1);
`ifdef SEGASYS_IOCTL_QSTATUS_EN
        rd_chk("stat1", 8'h19, 1'b1, 8'hA4);
        rd_chk("stat2", 8'h19, 1'b1, 8'h84);
        mdl_ovf = 1'b0;
`else
        rd_chk("stat_undec", 8'h19, 1'b0, 8'hFF);
`endif
        chk("ovf_qovf_after_rd", 32'(bus.QOVF), 32'(mdl_ovf));
        for (int i = 0; i < 4; i++) snd_ack();
        tick(3);
        chk("drain_rq", 32'(bus.SNDRQ), 32'd0);
        chk("drain_qfull", 32'(bus.QFULL), 32'd0);
        chk("drain_sb", 32'(sb.size()), 32'd0);

        // Reset while requesting, with a write strobe held across release
        push_cmd(8'h21); push_cmd(8'h22); push_cmd(8'h23);
        chk("pre_rst_rq", 32'(bus.SNDRQ), 32'd1);
        grst_n = 1'b0;
        bus.CPUAD = 8'h17; bus.CPUDO = 8'h5A; bus.CPUIORQ = 1'b1; bus.CPUWR = 1'b1;
        tick(1);
        chk("rst2_rq", 32'(bus.SNDRQ), 32'd0);
        chk("rst2_latch", bus.LATCH, 32'd0);
        chk("rst2_qovf", 32'(bus.QOVF), 32'd0);
        chk("rst2_qfull", 32'(bus.QFULL), 32'd0);
        sb.delete(); mdl_cnt = 0; mdl_ovf = 1'b0;
        grst_n = 1'b1;
        tick(1);
        chk("rel_evt", bus.LATCH, 32'h005A_0000);
        bus.CPUDO = 8'hA5;
        tick(3);
        chk("rel_once", bus.LATCH, 32'h005A_0000);
        bus.CPUIORQ = 1'b0; bus.CPUWR = 1'b0;
        tick(3);
        chk("rst2_empty_rq", 32'(bus.SNDRQ), 32'd0);

        // Full queue: push coincident with the ack pop
        for (int i = 0; i < 4; i++) push_cmd(8'h31 + 8'(i));
        tick(1);
        chk("full4", 32'(bus.QFULL), 32'd1);
        chk("full4_rq", 32'(bus.SNDRQ), 32'd1);
        chk("full4_no", 32'(bus.SNDNO), 32'(sb.pop_front()));
        bus.SNDACK = 1'b1;
        bus.CPUAD = 8'h14; bus.CPUDO = 8'h35; bus.CPUIORQ = 1'b1; bus.CPUWR = 1'b1;
        sb.push_back(8'h35);
        tick(1);
        chk("coinc_qfull", 32'(bus.QFULL), 32'd1);
        chk("coinc_qovf", 32'(bus.QOVF), 32'd0);
        chk("coinc_rq", 32'(bus.SNDRQ), 32'd0);
        bus.SNDACK = 1'b0; bus.CPUIORQ = 1'b0; bus.CPUWR = 1'b0;
        tick(1);
        for (int i = 0; i < 4; i++) snd_ack();
        tick(3);
        chk("end_rq", 32'(bus.SNDRQ), 32'd0);
        chk("end_qfull", 32'(bus.QFULL), 32'd0);
        chk("end_qovf", 32'(bus.QOVF), 32'd0);
        chk("end_sb", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
